// File: rtl/srrc_pkg.sv
// Shared SRRC constants for the 4-ASK modem: half-filter coefficients, tap lookup
// and the symbol-to-level map. The receive filter uses the same coefficients.
package srrc_pkg;

   localparam int SPS   = 4;
   localparam int NTAPS = 17;
   localparam int NSYM  = 5;

   typedef logic signed [17:0] smp_t;

   localparam smp_t LVL_A     = 18'sd32768;
   localparam smp_t LVL_OUTER = 18'sd98304;

   // Q1.17 half of the symmetric impulse response; b[8] is the centre tap
   localparam smp_t SRRC_B [0:8] = '{
      18'sd3259, -18'sd3378, -18'sd10461, -18'sd12207, -18'sd3946,
      18'sd14611, 18'sd38196, 18'sd57937, 18'sd65624
   };

   function automatic smp_t srrc_tap(input logic [4:0] n);
      logic [4:0] m;
      if (n > 5'd16) return '0;
      m = (n > 5'd8) ? 5'd16 - n : n;
      return SRRC_B[m[3:0]];
   endfunction

   function automatic smp_t ask4_level(input logic [1:0] sym);
      unique case (sym)
         2'b00:   return -LVL_OUTER;
         2'b01:   return -LVL_A;
         2'b10:   return LVL_A;
         default: return LVL_OUTER;
      endcase
   endfunction

endpackage

// File: rtl/srrc_tx_flt_if.sv
// Symbol-in / sample-out bundle of the transmit pulse shaper.
interface srrc_tx_flt_if;
   import srrc_pkg::*;

   logic [1:0] sym_in;
   logic       sym_valid;
   logic       sym_ready;
   smp_t       out;
   logic       out_valid;
   logic       underflow;

   modport master (
      output sym_in, sym_valid,
      input  sym_ready, out, out_valid, underflow
   );

   modport slave (
      input  sym_in, sym_valid,
      output sym_ready, out, out_valid, underflow
   );

endinterface

// File: rtl/srrc_tx_phase_mac.sv
// Polyphase multiply-accumulate: one output phase of the 17-tap SRRC interpolator
// from the five most recent symbol levels, truncated products, saturated sum.
module srrc_tx_phase_mac
   import srrc_pkg::*;
(
   input  smp_t       s [NSYM],
   input  logic [1:0] ph,
   output smp_t       y
);

   localparam logic signed [20:0] SAT_HI = 21'sd131071;
   localparam logic signed [20:0] SAT_LO = -21'sd131072;

   logic signed [35:0] prod;
   logic signed [20:0] acc;

   always_comb begin
      acc  = '0;
      prod = '0;
      // tap index 4*j+ph; taps beyond 16 come back as zero from srrc_tap
      for (int j = 0; j < NSYM; j++) begin
         prod = s[j] * srrc_tap(5'(4 * j) + {3'b000, ph});
         acc  = acc + {{3{prod[34]}}, prod[34:17]};
      end
      y = acc[17:0];
      if (acc > SAT_HI)
         y = SAT_HI[17:0];
      else if (acc < SAT_LO)
         y = SAT_LO[17:0];
   end

endmodule

// File: rtl/srrc_tx_flt.sv
// 4-ASK transmit SRRC pulse shaper, interpolate-by-4: symbol handshake, phase
// counter, symbol delay line and registered output sample.
module srrc_tx_flt
   import srrc_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   srrc_tx_flt_if.slave bus
);

   logic [1:0] ph;
   smp_t       s [NSYM];
   smp_t       mac_y;
   logic       started;
   logic       xfer;

   assign bus.sym_ready = en && (ph == 2'd3);
   assign xfer          = bus.sym_ready && bus.sym_valid;

   srrc_tx_phase_mac u_mac (
      .s  (s),
      .ph (ph),
      .y  (mac_y)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ph            <= 2'd3;
         started       <= 1'b0;
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
         bus.underflow <= 1'b0;
         for (int k = 0; k < NSYM; k++) s[k] <= '0;
      end else begin
         bus.underflow <= 1'b0;
         if (en) begin
            ph            <= ph + 2'd1;
            bus.out       <= mac_y;
            bus.out_valid <= started;
            // symbol slot: the line always advances; a missed slot injects a zero
            if (ph == 2'd3) begin
               for (int k = NSYM - 1; k > 0; k--) s[k] <= s[k-1];
               s[0]          <= xfer ? ask4_level(bus.sym_in) : '0;
               bus.underflow <= !bus.sym_valid;
               if (xfer) started <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_srrc_tx_flt.sv
// Self-checking bench for srrc_tx_flt: directed impulses, back-to-back stream,
// enable stalls, random traffic and async reset, against a convolution model.
module tb_srrc_tx_flt;

   logic clk;
   logic reset;
   logic en;

   int   tests;
   int   fails;
   int   ecnt;
   int   first_xfer;
   int   exp_out;
   logic exp_valid;
   int   ins_edge [$];
   int   ins_lvl  [$];
   int   b_tab [9];
   int   imp11 [17];
   logic [1:0] pat [4];

   srrc_tx_flt_if bus ();

   srrc_tx_flt dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int h(input int n);
      if (n < 0 || n > 16) return 0;
      return b_tab[(n <= 8) ? n : 16 - n];
   endfunction

   function automatic int level(input logic [1:0] sy);
      case (sy)
         2'b00:   return -98304;
         2'b01:   return -32768;
         2'b10:   return 32768;
         default: return 98304;
      endcase
   endfunction

   // output after enabled edge t = sum of each inserted slot convolved with h
   function automatic int model_out(input int t);
      longint acc;
      int     d;
      acc = 0;
      for (int i = 0; i < ins_edge.size(); i++) begin
         d = t - ins_edge[i] - 1;
         if (d >= 0 && d <= 16)
            acc += (longint'(ins_lvl[i]) * longint'(h(d))) >>> 17;
      end
      if (acc > 131071)  acc = 131071;
      if (acc < -131072) acc = -131072;
      return int'(acc);
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs, input int expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_clear();
      ecnt       = 0;
      first_xfer = -1;
      exp_out    = 0;
      exp_valid  = 1'b0;
      ins_edge.delete();
      ins_lvl.delete();
   endtask

   task automatic step(input logic e, input logic v, input logic [1:0] sy);
      logic slot;
      logic xf;
      @(negedge clk);
      en            = e;
      bus.sym_valid = v;
      bus.sym_in    = sy;
      slot          = e && (ecnt % 4 == 0);
      #1;
      check("sym_ready", bus.sym_ready, slot);
      @(posedge clk);
      #1;
      if (e) begin
         ecnt++;
         xf = slot && v;
         if (slot) begin
            ins_edge.push_back(ecnt);
            ins_lvl.push_back(xf ? level(sy) : 0);
         end
         if (xf && first_xfer < 0) first_xfer = ecnt;
         exp_out   = model_out(ecnt);
         exp_valid = (first_xfer >= 0) && (ecnt > first_xfer);
      end
      check("out", $signed(bus.out), exp_out);
      check("out_valid", bus.out_valid, exp_valid);
      check("underflow", bus.underflow, e && slot && !v);
   endtask

   task automatic send(input logic [1:0] sy);
      int guard;
      guard = 0;
      while (ecnt % 4 != 0 && guard < 8) begin
         step(1'b1, 1'b0, 2'b00);
         guard++;
      end
      step(1'b1, 1'b1, sy);
   endtask

   // caller positions time; no clock edge lies between assertion and first check
   task automatic reset_seq();
      reset = 1'b0;
      #1;
      check("rst_out", $signed(bus.out), 0);
      check("rst_valid", bus.out_valid, 0);
      check("rst_underflow", bus.underflow, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_out", $signed(bus.out), 0);
      check("rst_hold_valid", bus.out_valid, 0);
      @(negedge clk);
      en            = 1'b0;
      bus.sym_valid = 1'b0;
      bus.sym_in    = 2'b00;
      reset         = 1'b1;
      model_clear();
   endtask

   task automatic impulse_11();
      send(2'b11);
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 1'b0, 2'b00);
         check("imp11", $signed(bus.out), imp11[i]);
      end
      step(1'b1, 1'b0, 2'b00);
      check("imp11_tail", $signed(bus.out), 0);
   endtask

   initial begin
      logic [1:0] sy;
      int         pidx;
      int         guard;
      logic       e;
      logic       v;

      b_tab = '{3259, -3378, -10461, -12207, -3946, 14611, 38196, 57937, 65624};
      imp11 = '{2444, -2534, -7846, -9156, -2960, 10958, 28647, 43452, 49218,
                43452, 28647, 10958, -2960, -9156, -7846, -2534, 2444};
      pat   = '{2'b11, 2'b00, 2'b10, 2'b01};
      tests = 0;
      fails = 0;
      reset         = 1'b1;
      en            = 1'b0;
      bus.sym_valid = 1'b0;
      bus.sym_in    = 2'b00;
      model_clear();

      #2;
      reset_seq();

      // idle after release: underflow once per four cycles
      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 2'b00);

      impulse_11();

      send(2'b01);
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 1'b0, 2'b00);
         if (i == 0) check("imp01_first", $signed(bus.out), -815);
         if (i == 8) check("imp01_peak", $signed(bus.out), -16406);
      end

      // back-to-back with a 3-cycle enable stall in the middle
      pidx = 0;
      for (int i = 0; i < 48; i++) begin
         if (i >= 22 && i < 25) begin
            step(1'b0, 1'b1, pat[pidx]);
            check("stall_hold_out", $signed(bus.out), exp_out);
         end else begin
            sy = pat[pidx];
            if (ecnt % 4 == 0) pidx = (pidx + 1) % 4;
            step(1'b1, 1'b1, sy);
         end
      end

      // random traffic: sporadic stalls, missed slots, all symbols
      for (int i = 0; i < 200; i++) begin
         e  = ($urandom_range(0, 7) != 0);
         v  = ($urandom_range(0, 3) != 0);
         sy = 2'($urandom_range(0, 3));
         step(e, v, sy);
      end

      // async reset while ph==1 with a symbol pending
      guard = 0;
      while (ecnt % 4 != 2 && guard < 8) begin
         step(1'b1, 1'b1, 2'b10);
         guard++;
      end
      check("mid_ph1_reached", (ecnt % 4 == 2), 1);
      bus.sym_valid = 1'b1;
      bus.sym_in    = 2'b11;
      #2;
      reset_seq();

      for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 2'b00);
      impulse_11();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
